// File: rtl/cast_resize_pipe.sv
// -----------------------------------------------------------------------------
// cast_resize_pipe
//
// Purpose:
//   Per-beat integer width cast (resize / saturate) feeding a 2-entry skid
//   buffer with valid/ready handshakes on both sides. A saturating counter
//   tallies delivered beats whose result does not represent the operand
//   exactly.
//
// Configuration macro:
//   CAST_RESIZE_SAT_EN - when defined, modes 10/11 clamp to the output range.
//                        When undefined, mode 10 behaves as mode 01 and mode 11
//                        as mode 00, and no clamp logic is built.
//
// Parameters:
//   IN_W   operand width (>=1)
//   OUT_W  result width (>=1, any relation to IN_W)
//   CNT_W  lossy-event counter width
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat offered
//   in_ready   input beat accepted when in_valid & in_ready (driven by a flop)
//   in_data    operand
//   in_mode    00 unsigned resize, 01 signed resize,
//              10 signed saturate, 11 unsigned saturate
//   out_valid  result beat offered
//   out_ready  result consumed when out_valid & out_ready
//   out_data   cast result
//   out_lossy  result does not represent the operand exactly
//   ovf_clear  synchronous clear of ovf_count (wins over an increment)
//   ovf_count  saturating count of lossy beats delivered
// -----------------------------------------------------------------------------
module cast_resize_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_lossy,
  input  logic             ovf_clear,
  output logic [CNT_W-1:0] ovf_count
);

  // Working width: one bit wider than either side so both sign- and
  // zero-extended forms of operand and result are exact.
  localparam int W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

  // ---------------------------------------------------------------------------
  // Cast datapath
  // ---------------------------------------------------------------------------
  logic             w_signed;
  logic [W-1:0]     w_ext;
  logic [OUT_W-1:0] w_trunc;
  logic [W-1:0]     w_back;
  logic             w_fits;
  logic [OUT_W-1:0] w_cast_data;
  logic             w_cast_lossy;

  always_comb begin
    // Modes 01 and 10 treat the operand as signed; 00 and 11 as unsigned.
    w_signed = in_mode[0] ^ in_mode[1];
    w_ext    = w_signed ? {{(W-IN_W){in_data[IN_W-1]}}, in_data}
                        : {{(W-IN_W){1'b0}}, in_data};
    w_trunc  = w_ext[OUT_W-1:0];
    // Re-extend the truncated value under the same signedness: if it comes
    // back identical, the result represents the operand exactly.
    w_back   = w_signed ? {{(W-OUT_W){w_trunc[OUT_W-1]}}, w_trunc}
                        : {{(W-OUT_W){1'b0}}, w_trunc};
    w_fits   = (w_back == w_ext);

    w_cast_data  = w_trunc;
    w_cast_lossy = !w_fits;
`ifdef CAST_RESIZE_SAT_EN
    // Out of range in a saturating mode: clamp toward the operand's side.
    if (in_mode[1] && !w_fits) begin
      if (w_signed) begin
        w_cast_data            = in_data[IN_W-1] ? '0 : '1;
        w_cast_data[OUT_W-1]   = in_data[IN_W-1];
      end else begin
        w_cast_data = '1;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid buffer: r_main_* drives the outputs, r_skid_* catches the
  // beat accepted while the output is stalled. in_ready is a flop that is
  // low exactly when the skid entry is occupied.
  // ---------------------------------------------------------------------------
  logic             r_main_valid;
  logic [OUT_W-1:0] r_main_data;
  logic             r_main_lossy;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic             r_skid_lossy;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_deliver;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_lossy <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_lossy <= 1'b0;
      r_in_ready   <= 1'b1;
      r_cnt        <= '0;
    end else begin
      if (!r_main_valid || out_ready) begin
        // Output slot frees up this edge: refill from skid first to keep
        // order, else from the incoming beat.
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= r_skid_data;
          r_main_lossy <= r_skid_lossy;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_accept) begin
          r_main_valid <= 1'b1;
          r_main_data  <= w_cast_data;
          r_main_lossy <= w_cast_lossy;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        // Output stalled and already holding a beat: park the new one.
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_cast_data;
        r_skid_lossy <= w_cast_lossy;
        r_in_ready   <= 1'b0;
      end

      if (ovf_clear) begin
        r_cnt <= '0;
      end else if (w_deliver && r_main_lossy && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_lossy = r_main_lossy;
  assign ovf_count = r_cnt;

endmodule
